// File: rtl/vga_pkg.sv
// Shared VGA definitions: RGB332 pixel type, common colours, active-area size
// and the sprite pipeline latency the timing block must match.
package vga_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  localparam logic [7:0] COLOR_WHITE = 8'hFF;
  localparam logic [7:0] COLOR_BLACK = 8'h00;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int SPRITE_LAT = 2;

endpackage

// File: rtl/sprite_blink_ctr.sv
// Frame-counted blink generator: phase toggles every BLINK_FRAMES frame_start
// pulses while blinking is enabled, and is held visible (1) otherwise.
module sprite_blink_ctr #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic blink_en,
  output logic phase
);

  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (!blink_en) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (frame_start) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_renderer.sv
// Pipelined sprite overlay: maps (hc, vc) into a ROM-held image without a
// multiplier and drives RGB332 with colour-key transparency and blinking.
module sprite_renderer
  import vga_pkg::*;
#(
  parameter int         IMG_W        = 93,
  parameter int         IMG_H        = 90,
  parameter int         ADDR_W       = 15,
  parameter int         COORD_W      = 11,
  parameter logic [7:0] KEY_COLOR    = COLOR_BLACK,
  parameter logic [7:0] BG_COLOR     = COLOR_WHITE,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hc,
  input  logic [COORD_W-1:0] vc,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               enable,
  input  logic               blink_en,
  input  logic [7:0]         mem_value,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic [2:0]         R,
  output logic [2:0]         G,
  output logic [1:0]         B,
  output logic               opaque
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0]    IMG_W_C = CW1'(IMG_W);
  localparam logic [CW1-1:0]    IMG_H_C = CW1'(IMG_H);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  logic [COORD_W-1:0] px, py, vc_prev;
  logic               en_l, blink_l, phase;
  logic [ADDR_W-1:0]  row_base, row_eff, col_addr;
  logic [CW1-1:0]     hc_x, vc_x, px_x, py_x, col_off;
  logic               in_win, line_change, vis_d1;
  rgb332_t            rgb_q;

  sprite_blink_ctr #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .blink_en    (blink_l),
    .phase       (phase)
  );

  // Position and visibility are frozen per frame so mid-frame updates never tear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px      <= '0;
      py      <= '0;
      en_l    <= 1'b0;
      blink_l <= 1'b0;
    end else if (frame_start) begin
      px      <= pos_x;
      py      <= pos_y;
      en_l    <= enable;
      blink_l <= blink_en;
    end
  end

  // One extra bit keeps px+IMG_W from wrapping near the coordinate limit.
  assign hc_x    = {1'b0, hc};
  assign vc_x    = {1'b0, vc};
  assign px_x    = {1'b0, px};
  assign py_x    = {1'b0, py};
  assign in_win  = (hc_x >= px_x) && (hc_x < px_x + IMG_W_C) &&
                   (vc_x >= py_x) && (vc_x < py_x + IMG_H_C);
  assign col_off  = hc_x - px_x;
  assign col_addr = ADDR_W'(col_off);
  assign line_change = (vc != vc_prev);

  // The updated row base is used in the same cycle the line changes, so a
  // sprite starting at hc=0 still gets the right address on its first pixel.
  always_comb begin
    row_eff = row_base;
    if (line_change) begin
      if (vc == py) begin
        row_eff = '0;
      end else if ((vc_x > py_x) && (vc_x < py_x + IMG_H_C)) begin
        row_eff = row_base + IMG_W_A;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc_prev  <= '0;
      row_base <= '0;
      rom_addr <= '0;
      vis_d1   <= 1'b0;
    end else begin
      vc_prev  <= vc;
      row_base <= row_eff;
      rom_addr <= in_win ? (row_eff + col_addr) : '0;
      vis_d1   <= in_win && en_l && phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q  <= rgb332_t'(BG_COLOR);
      opaque <= 1'b0;
    end else if (vis_d1 && (mem_value != KEY_COLOR)) begin
      rgb_q  <= rgb332_t'(mem_value);
      opaque <= 1'b1;
    end else begin
      rgb_q  <= rgb332_t'(BG_COLOR);
      opaque <= 1'b0;
    end
  end

  assign R = rgb_q.r;
  assign G = rgb_q.g;
  assign B = rgb_q.b;

endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer: hand-computed vector table plus a
// geometric reference model (row*IMG_W+col, frame-count blink) over scans.
module tb_sprite_renderer;
  import vga_pkg::*;

  localparam int         IMG_W   = 93;
  localparam int         IMG_H   = 90;
  localparam int         ADDR_W  = 15;
  localparam int         COORD_W = 11;
  localparam int         BF      = 2;
  localparam logic [7:0] KEY     = 8'h00;
  localparam logic [7:0] BG      = 8'hFF;

  logic               clk;
  logic               rst_n;
  logic [COORD_W-1:0] hc, vc, pos_x, pos_y;
  logic               frame_start, enable, blink_en;
  logic [7:0]         mem_value;
  logic [ADDR_W-1:0]  rom_addr;
  logic [2:0]         R, G;
  logic [1:0]         B;
  logic               opaque;

  int tests_run = 0;
  int tests_failed = 0;

  int rom_mode = 0;

  int m_px, m_py, m_n, prev_addr;
  bit m_en, m_blink, prev_vis;

  int spot_h[2], spot_v[2], spot_a[2];
  int opaque_count;
  int res_rgb[640];
  bit res_op[640];

  typedef struct {
    int h;
    int v;
    int addr;
    int rgb;
    bit op;
  } vec_t;
  vec_t tbl[8];

  sprite_renderer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .COORD_W(COORD_W),
    .KEY_COLOR(KEY), .BG_COLOR(BG), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .frame_start(frame_start),
    .pos_x(pos_x), .pos_y(pos_y), .enable(enable), .blink_en(blink_en),
    .mem_value(mem_value), .rom_addr(rom_addr), .R(R), .G(G), .B(B),
    .opaque(opaque)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (rom_mode == 0) mem_value = rom_addr[7:0];
    else               mem_value = (rom_addr == 15'd5) ? 8'h00 : 8'h3C;
  end

  function automatic int rom_ref(input int a);
    if (rom_mode == 0) return a % 256;
    return (a == 5) ? 0 : 'h3C;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_px = 0; m_py = 0; m_en = 0; m_blink = 0; m_n = 0;
    prev_addr = 0; prev_vis = 0;
  endtask

  // Drive one pixel, advance one clock and compare against the model.
  task automatic applyStimulus(input bit fs, input int h, input int v);
    int exp_addr, pdata, exp_rgb;
    bit inw, ph, vis, exp_op;
    frame_start = fs;
    hc = COORD_W'(h);
    vc = COORD_W'(v);
    ph  = ((m_n / BF) % 2) == 0;
    inw = (h >= m_px) && (h < m_px + IMG_W) && (v >= m_py) && (v < m_py + IMG_H);
    exp_addr = inw ? (v - m_py) * IMG_W + (h - m_px) : 0;
    pdata  = rom_ref(prev_addr);
    exp_op = prev_vis && (pdata != int'(KEY));
    exp_rgb = exp_op ? pdata : int'(BG);
    vis = inw && m_en && ph;
    if (fs) begin
      m_n = m_blink ? m_n + 1 : 0;
      m_px = int'(pos_x); m_py = int'(pos_y);
      m_en = enable; m_blink = blink_en;
      if (!m_blink) m_n = 0;
    end
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    checkOutput("rom_addr", int'(rom_addr), exp_addr);
    checkOutput("rgb", int'({R, G, B}), exp_rgb);
    checkOutput("opaque", int'(opaque), int'(exp_op));
    prev_addr = exp_addr;
    prev_vis  = vis;
    opaque_count += int'(opaque);
  endtask

  task automatic newFrame();
    applyStimulus(1'b1, 0, 0);
  endtask

  task automatic scanLines(input int y0, input int y1, input int x0, input int x1);
    for (int v = y0; v <= y1; v++) begin
      for (int h = x0; h <= x1; h++) begin
        applyStimulus(1'b0, h, v);
        for (int i = 0; i < 2; i++)
          if (h == spot_h[i] && v == spot_v[i])
            checkOutput("spot_addr", int'(rom_addr), spot_a[i]);
      end
    end
  endtask

  task automatic clearSpots();
    for (int i = 0; i < 2; i++) begin
      spot_h[i] = -1; spot_v[i] = -1; spot_a[i] = 0;
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic doReset();
    frame_start = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_addr", int'(rom_addr), 0);
    checkOutput("reset_rgb", int'({R, G, B}), int'(BG));
    checkOutput("reset_opaque", int'(opaque), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold_opaque", int'(opaque), 0);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Pixels on lines 300/301 of a sprite at (273,300), ROM = addr[7:0].
    tbl[0] = '{272, 300, 0,   'hFF, 1'b0};
    tbl[1] = '{273, 300, 0,   'hFF, 1'b0};
    tbl[2] = '{274, 300, 1,   'hFF, 1'b0};
    tbl[3] = '{365, 300, 92,  'h01, 1'b1};
    tbl[4] = '{366, 300, 0,   'h5C, 1'b1};
    tbl[5] = '{273, 301, 93,  'hFF, 1'b0};
    tbl[6] = '{300, 301, 120, 'h5D, 1'b1};
    tbl[7] = '{300, 301, 120, 'h78, 1'b1};

    hc = '0; vc = '0; frame_start = 1'b0;
    pos_x = '0; pos_y = '0; enable = 1'b0; blink_en = 1'b0;
    opaque_count = 0;
    clearSpots();
    modelReset();
    rst_n = 1'b1;
    #2;
    doReset();

    pos_x = 273; pos_y = 300; enable = 1'b1; blink_en = 1'b0;
    newFrame();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, tbl[i].h, tbl[i].v);
      checkOutput("tbl_addr", int'(rom_addr), tbl[i].addr);
      checkOutput("tbl_rgb", int'({R, G, B}), tbl[i].rgb);
      checkOutput("tbl_opaque", int'(opaque), int'(tbl[i].op));
    end

    // Full sprite scan with corner addresses.
    spot_h[0] = 273; spot_v[0] = 300; spot_a[0] = 0;
    spot_h[1] = 365; spot_v[1] = 389; spot_a[1] = 8369;
    newFrame();
    scanLines(298, 392, 268, 370);
    clearSpots();

    // Transparency at address 5.
    rom_mode = 1;
    newFrame();
    for (int h = 270; h <= 282; h++) begin
      applyStimulus(1'b0, h, 300);
      res_rgb[h-1] = int'({R, G, B});
      res_op[h-1]  = opaque;
    end
    checkOutput("key_pixel_rgb", res_rgb[278], int'(BG));
    checkOutput("key_pixel_opaque", int'(res_op[278]), 0);
    checkOutput("left_neighbour_opaque", int'(res_op[277]), 1);
    checkOutput("right_neighbour_opaque", int'(res_op[279]), 1);

    // Mid-frame position change only applies from the next frame.
    rom_mode = 0;
    newFrame();
    scanLines(298, 349, 268, 370);
    pos_x = 100;
    scanLines(350, 392, 95, 370);
    spot_h[0] = 100; spot_v[0] = 300; spot_a[0] = 0;
    spot_h[1] = 192; spot_v[1] = 389; spot_a[1] = 8369;
    newFrame();
    scanLines(298, 392, 95, 200);
    clearSpots();

    // Clipping at the bottom-right of the active area.
    pos_x = 600; pos_y = 450;
    spot_h[0] = H_ACTIVE - 1; spot_v[0] = V_ACTIVE - 1; spot_a[0] = 2736;
    newFrame();
    scanLines(445, V_ACTIVE - 1, 595, H_ACTIVE - 1);
    clearSpots();

    // Reset in the middle of the sprite; hidden until the next frame latch.
    rom_mode = 1;
    pos_x = 273; pos_y = 300;
    newFrame();
    scanLines(298, 319, 268, 370);
    for (int h = 268; h <= 300; h++) applyStimulus(1'b0, h, 320);
    checkOutput("pre_reset_opaque", int'(opaque), 1);
    doReset();
    opaque_count = 0;
    scanLines(321, 330, 268, 370);
    checkOutput("post_reset_hidden", opaque_count, 0);
    newFrame();
    opaque_count = 0;
    scanLines(298, 305, 268, 370);
    checkOutput("relatch_visible", int'(opaque_count > 0), 1);

    // Blink with a two-frame half-period.
    blink_en = 1'b1;
    for (int f = 0; f < 7; f++) begin
      newFrame();
      opaque_count = 0;
      scanLines(299, 302, 270, 280);
      checkOutput("blink_visible", int'(opaque_count > 0), int'((f % 4) < 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
